// File: rtl/flit_sink.sv
// Packet-receiving endpoint: checks HEAD/DATA/TAIL framing, records packet lengths and
// counts payload bit toggles. Define FLIT_SINK_TOGGLE_EN to build the toggle accumulator.
module flit_sink #(
  parameter int DATAW = 64,
  parameter int TYPEW = 2,
  parameter int VCHW  = 2,
  parameter int LENW  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATAW+TYPEW-1:0] idata,
  input  logic                   ivalid,
  input  logic [VCHW-1:0]        ivch,
  input  logic                   clr,
  output logic                   busy,
  output logic                   pkt_done,
  output logic [LENW-1:0]        last_len,
  output logic [15:0]            pkt_cnt,
  output logic [31:0]            flit_cnt,
  output logic [31:0]            toggle_cnt,
  output logic                   err,
  output logic [2:0]             err_code
);

  typedef enum logic {IDLE, BODY} state_t;

  localparam logic [TYPEW-1:0] T_NONE = TYPEW'(0);
  localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(1);
  localparam logic [TYPEW-1:0] T_DATA = TYPEW'(2);
  localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(3);

  localparam logic [2:0] ERR_NOHEAD = 3'd1;
  localparam logic [2:0] ERR_TYPE   = 3'd2;
  localparam logic [2:0] ERR_VCH    = 3'd3;
  localparam logic [2:0] ERR_LEN    = 3'd4;
  localparam logic [2:0] ERR_NESTED = 3'd5;

  state_t            state, next_state;
  logic [VCHW-1:0]   cur_vch, next_vch;
  logic [LENW-1:0]   len, next_len;
  logic              err_hit, close;
  logic [2:0]        err_val;
  logic [TYPEW-1:0]  ftype;
  logic [DATAW-1:0]  payload;

  assign ftype   = idata[DATAW+TYPEW-1:DATAW];
  assign payload = idata[DATAW-1:0];
  assign busy    = (state == BODY);

  // A VC mismatch inside a packet is checked before the flit type is looked at
  always_comb begin
    next_state = state;
    next_vch   = cur_vch;
    next_len   = len;
    err_hit    = 1'b0;
    err_val    = 3'd0;
    close      = 1'b0;
    if (ivalid) begin
      if (state == IDLE) begin
        if (ftype == T_HEAD) begin
          next_state = BODY;
          next_vch   = ivch;
          next_len   = '0;
        end else if (ftype == T_NONE) begin
          err_hit = 1'b1;
          err_val = ERR_TYPE;
        end else begin
          err_hit = 1'b1;
          err_val = ERR_NOHEAD;
        end
      end else if (ivch != cur_vch) begin
        err_hit = 1'b1;
        err_val = ERR_VCH;
      end else begin
        case (ftype)
          T_DATA: begin
            if (&len) begin
              err_hit = 1'b1;
              err_val = ERR_LEN;
            end else begin
              next_len = len + LENW'(1);
            end
          end
          T_TAIL: begin
            close      = 1'b1;
            next_state = IDLE;
          end
          T_HEAD: begin
            err_hit  = 1'b1;
            err_val  = ERR_NESTED;
            next_len = '0;
            next_vch = ivch;
          end
          default: begin
            err_hit = 1'b1;
            err_val = ERR_TYPE;
          end
        endcase
      end
    end
  end

  // clr drops this cycle's counter/error contributions but framing still advances
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_vch  <= '0;
      len      <= '0;
      pkt_done <= 1'b0;
      last_len <= '0;
      pkt_cnt  <= '0;
      flit_cnt <= '0;
      err      <= 1'b0;
      err_code <= 3'd0;
    end else begin
      state    <= next_state;
      cur_vch  <= next_vch;
      len      <= next_len;
      pkt_done <= close;
      if (clr) begin
        last_len <= '0;
        pkt_cnt  <= '0;
        flit_cnt <= '0;
        err      <= 1'b0;
        err_code <= 3'd0;
      end else if (ivalid) begin
        flit_cnt <= (&flit_cnt) ? flit_cnt : flit_cnt + 32'd1;
        if (close) begin
          last_len <= len;
          pkt_cnt  <= (&pkt_cnt) ? pkt_cnt : pkt_cnt + 16'd1;
        end
        if (err_hit) begin
          err <= 1'b1;
          if (!err) err_code <= err_val;
        end
      end
    end
  end

`ifdef FLIT_SINK_TOGGLE_EN
  logic [DATAW-1:0] prev_data;
  logic [32:0]      toggle_sum;

  assign toggle_sum = {1'b0, toggle_cnt} + 33'($countones(payload ^ prev_data));

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_data  <= '0;
      toggle_cnt <= '0;
    end else begin
      if (ivalid) prev_data <= payload;
      if (clr) toggle_cnt <= '0;
      else if (ivalid) toggle_cnt <= toggle_sum[32] ? 32'hFFFF_FFFF : toggle_sum[31:0];
    end
  end
`else
  logic unused_payload;
  assign unused_payload = ^payload;
  assign toggle_cnt     = '0;
`endif

endmodule
